// File: rtl/rvfpm_xif_offloader.sv
// rvfpm_xif_offloader
//   Core-side X-interface initiator for rvfpm. It takes one FP instruction and
//   its operands from the core and issues it to the FPU. One cycle after the
//   issue handshake it commits or kills that instruction. It tracks accepted,
//   uncompleted transaction IDs in a scoreboard and forwards FPU results to
//   the core's integer writeback port.
//
//   Ports
//     ck, rst                     clock (rising edge), async active-low reset
//     instr_valid/ready, instr,
//     rs1, rs2                    instruction intake from core decode
//     flush                       kill the next commit, then drain outstanding work
//     issue_*                     issue handshake and held payload to the FPU
//     commit_valid/id/kill        one-cycle commit strobe
//     illegal                     one-cycle pulse when the FPU rejects an issue
//     result_*                    result channel from the FPU
//     wb_*                        integer writeback to the core
//     outstanding                 accepted, uncompleted transaction count
//     protocol_err                sticky: result seen for a non-outstanding ID
//     timeout_err                 sticky watchdog flag
//
//   Build option: define RVFPM_XIF_TIMEOUT_EN to include the watchdog.
//   Without it, timeout_err is tied low.
//
//   state  | meaning
//   IDLE   | waiting for an instruction from the core
//   ISSUE  | issue_valid held with stable payload until the FPU takes it
//   COMMIT | commit strobe cycle for the just-issued ID
//   DRAIN  | flush seen; intake blocked until outstanding reaches 0
module rvfpm_xif_offloader #(
    parameter int X_ID_WIDTH      = 4,
    parameter int XLEN            = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                                 ck,
    input  logic                                 rst,
    input  logic                                 instr_valid,
    output logic                                 instr_ready,
    input  logic [31:0]                          instr,
    input  logic [XLEN-1:0]                      rs1,
    input  logic [XLEN-1:0]                      rs2,
    input  logic                                 flush,
    output logic                                 issue_valid,
    input  logic                                 issue_ready,
    output logic [31:0]                          issue_instr,
    output logic [X_ID_WIDTH-1:0]                issue_id,
    output logic [XLEN-1:0]                      issue_rs0,
    output logic [XLEN-1:0]                      issue_rs1,
    input  logic                                 issue_accept,
    input  logic                                 issue_writeback,
    output logic                                 commit_valid,
    output logic [X_ID_WIDTH-1:0]                commit_id,
    output logic                                 commit_kill,
    output logic                                 illegal,
    input  logic                                 result_valid,
    output logic                                 result_ready,
    input  logic [X_ID_WIDTH-1:0]                result_id,
    input  logic [XLEN-1:0]                      result_data,
    input  logic [4:0]                           result_rd,
    input  logic                                 result_we,
    output logic                                 wb_valid,
    input  logic                                 wb_ready,
    output logic [4:0]                           wb_rd,
    output logic [XLEN-1:0]                      wb_data,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                                 protocol_err,
    output logic                                 timeout_err
);

    localparam int NUM_IDS = 1 << X_ID_WIDTH;
    localparam int OW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_COMMIT, ST_DRAIN} state_t;

    state_t                  state;
    logic                    live;        // holds intake closed during reset
    logic                    flush_seen;  // flush observed since capture
    logic [X_ID_WIDTH-1:0]   next_id;
    logic [NUM_IDS-1:0]      scoreboard;
    logic [NUM_IDS-1:0]      sb_next;

    logic issue_hs, result_hs, id_live, flushed, sb_set, sb_clr;

    // The result side carries its own write enable, so the issue-time
    // writeback hint carries no extra information here.
    logic unused_writeback;
    assign unused_writeback = issue_writeback;

    assign issue_hs  = issue_valid & issue_ready;
    assign result_hs = result_valid & wb_ready;
    assign id_live   = scoreboard[result_id];
    assign flushed   = flush_seen | flush;
    assign sb_set    = issue_hs & issue_accept & ~flushed;
    assign sb_clr    = result_hs & id_live;

    assign instr_ready  = live && (state == ST_IDLE) && (outstanding < MAX_OUT)
                          && !scoreboard[next_id] && !flush;
    assign result_ready = wb_ready;
    assign wb_valid     = result_valid & result_we & id_live;
    assign wb_rd        = result_rd;
    assign wb_data      = result_data;

    // Set and clear never target the same ID: an ID is only reissued once
    // its scoreboard bit is clear, and results for clear IDs are dropped.
    always_comb begin
        sb_next = scoreboard;
        if (sb_clr) sb_next[result_id] = 1'b0;
        if (sb_set) sb_next[issue_id]  = 1'b1;
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            live         <= 1'b0;
            flush_seen   <= 1'b0;
            next_id      <= '0;
            scoreboard   <= '0;
            outstanding  <= '0;
            issue_valid  <= 1'b0;
            issue_instr  <= '0;
            issue_id     <= '0;
            issue_rs0    <= '0;
            issue_rs1    <= '0;
            commit_valid <= 1'b0;
            commit_id    <= '0;
            commit_kill  <= 1'b0;
            illegal      <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            live         <= 1'b1;
            commit_valid <= 1'b0;
            commit_kill  <= 1'b0;
            illegal      <= 1'b0;
            scoreboard   <= sb_next;

            case ({sb_set, sb_clr})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase

            if (result_hs && !id_live) protocol_err <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (instr_valid && instr_ready) begin
                        state       <= ST_ISSUE;
                        issue_valid <= 1'b1;
                        issue_instr <= instr;
                        issue_rs0   <= rs1;
                        issue_rs1   <= rs2;
                        issue_id    <= next_id;
                        flush_seen  <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (flush) flush_seen <= 1'b1;
                    if (issue_ready) begin
                        state        <= ST_COMMIT;
                        issue_valid  <= 1'b0;
                        next_id      <= next_id + X_ID_WIDTH'(1);
                        commit_valid <= 1'b1;
                        commit_id    <= issue_id;
                        commit_kill  <= ~issue_accept | flushed;
                        illegal      <= ~issue_accept;
                    end
                end
                ST_COMMIT: begin
                    state <= flushed ? ST_DRAIN : ST_IDLE;
                end
                default: begin
                    if (outstanding == '0) state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef RVFPM_XIF_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES);

    // Down-counter reloaded while idle or on result progress; the flag sets
    // on the TIMEOUT_CYCLES-th consecutive cycle with work outstanding.
    logic [TW-1:0] tmr;

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            tmr         <= TMR_LOAD;
            timeout_err <= 1'b0;
        end else if (outstanding == '0 || result_hs) begin
            tmr <= TMR_LOAD;
        end else begin
            if (tmr == TW'(1)) timeout_err <= 1'b1;
            if (tmr != '0)     tmr <= tmr - TW'(1);
        end
    end
`else
    // The watchdog limit only matters when the watchdog is built in.
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT_CYCLES;
    assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_rvfpm_xif_offloader.sv
module tb_rvfpm_xif_offloader;

    logic        ck = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid = 1'b0, instr_ready;
    logic [31:0] instr = '0, rs1 = '0, rs2 = '0;
    logic        flush = 1'b0;
    logic        issue_valid, issue_ready = 1'b0;
    logic [31:0] issue_instr, issue_rs0, issue_rs1;
    logic [3:0]  issue_id;
    logic        issue_accept = 1'b0, issue_writeback = 1'b0;
    logic        commit_valid, commit_kill, illegal;
    logic [3:0]  commit_id;
    logic        result_valid = 1'b0, result_ready;
    logic [3:0]  result_id = '0;
    logic [31:0] result_data = '0;
    logic [4:0]  result_rd = '0;
    logic        result_we = 1'b0;
    logic        wb_valid, wb_ready = 1'b0;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [2:0]  outstanding;
    logic        protocol_err, timeout_err;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] FADD = 32'h0031_00D3;

    always #5 ck = ~ck;

    rvfpm_xif_offloader #(
        .X_ID_WIDTH(4), .XLEN(32), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .ck(ck), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .rs1(rs1), .rs2(rs2), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_instr(issue_instr), .issue_id(issue_id),
        .issue_rs0(issue_rs0), .issue_rs1(issue_rs1),
        .issue_accept(issue_accept), .issue_writeback(issue_writeback),
        .commit_valid(commit_valid), .commit_id(commit_id),
        .commit_kill(commit_kill), .illegal(illegal),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_id(result_id), .result_data(result_data),
        .result_rd(result_rd), .result_we(result_we),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .outstanding(outstanding), .protocol_err(protocol_err),
        .timeout_err(timeout_err)
    );

    // stim: {iv, issue_ready, accept, writeback, result_valid, result_id[3:0], we, wb_ready, flush}
    // exp:  {instr_ready, issue_valid, commit_valid, commit_kill, illegal,
    //        wb_valid, result_ready, outstanding[2:0], protocol_err}
    typedef struct {
        logic [12:0] stim;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        instr_valid = 1'b0; issue_ready = 1'b0; issue_accept = 1'b0;
        issue_writeback = 1'b0; result_valid = 1'b0; result_id = '0;
        result_we = 1'b0; wb_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge ck);
        clear_inputs();
        rst = 1'b0;
        #1;
        chk("rst_outputs",
            32'({instr_ready, issue_valid, commit_valid, commit_kill, illegal,
                 outstanding, protocol_err, timeout_err, issue_id}), 32'h0);
        @(negedge ck);
        rst = 1'b1;
    endtask

    // Intake, issue handshake, then check the commit cycle. Ends in COMMIT.
    task automatic run_txn(input logic acc, input logic fl, input logic [3:0] exp_id);
        int n;
        @(negedge ck);
        instr_valid = 1'b1; instr = FADD; rs1 = 32'h3F80_0000; rs2 = 32'h4000_0000;
        #1;
        n = 0;
        while (!instr_ready && n < 40) begin
            @(negedge ck); #1; n++;
        end
        chk("txn_instr_ready", 32'(instr_ready), 32'h1);
        @(negedge ck);
        instr_valid = 1'b0; issue_ready = 1'b1; issue_accept = acc;
        issue_writeback = 1'b1; flush = fl;
        #1;
        chk("txn_issue", 32'({issue_valid, issue_id}), 32'({1'b1, exp_id}));
        @(negedge ck);
        issue_ready = 1'b0; issue_accept = 1'b0; flush = 1'b0;
        #1;
        chk("txn_commit", 32'({commit_valid, commit_id, commit_kill, illegal}),
            32'({1'b1, exp_id, ~acc | fl, ~acc}));
    endtask

    task automatic send_result(input logic [3:0] id, input logic we, input logic exp_wb,
                               input logic [2:0] exp_out);
        @(negedge ck);
        result_valid = 1'b1; result_id = id; result_we = we; wb_ready = 1'b1;
        result_data = 32'h4040_0000 ^ 32'(id); result_rd = 5'd5 + 5'(id);
        #1;
        chk("res_wb_valid", 32'(wb_valid), 32'(exp_wb));
        if (exp_wb)
            chk("res_wb_payload", {wb_data[26:0], wb_rd},
                {27'(32'h4040_0000 ^ 32'(id)), 5'd5 + 5'(id)});
        @(negedge ck);
        result_valid = 1'b0; result_we = 1'b0; wb_ready = 1'b0;
        #1;
        chk("res_outstanding", 32'(outstanding), 32'(exp_out));
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{13'b1_0_0_0_0_0000_0_0_0, 11'b1_0_0_0_0_0_0_000_0};
        tbl[1]  = '{13'b0_1_1_1_0_0000_0_0_0, 11'b0_1_0_0_0_0_0_000_0};
        tbl[2]  = '{13'b0_0_0_0_0_0000_0_0_0, 11'b0_0_1_0_0_0_0_001_0};
        tbl[3]  = '{13'b0_0_0_0_1_0000_1_1_0, 11'b1_0_0_0_0_1_1_001_0};
        tbl[4]  = '{13'b0_0_0_0_0_0000_0_0_0, 11'b1_0_0_0_0_0_0_000_0};
        tbl[5]  = '{13'b1_0_0_0_0_0000_0_0_1, 11'b0_0_0_0_0_0_0_000_0};
        tbl[6]  = '{13'b0_0_0_0_0_0000_0_0_0, 11'b1_0_0_0_0_0_0_000_0};
        tbl[7]  = '{13'b1_0_0_0_0_0000_0_0_0, 11'b1_0_0_0_0_0_0_000_0};
        tbl[8]  = '{13'b0_1_0_0_0_0000_0_0_0, 11'b0_1_0_0_0_0_0_000_0};
        tbl[9]  = '{13'b0_0_0_0_0_0000_0_0_0, 11'b0_0_1_1_1_0_0_000_0};
        tbl[10] = '{13'b0_0_0_0_0_0000_0_0_0, 11'b1_0_0_0_0_0_0_000_0};
        tbl[11] = '{13'b1_0_0_0_0_0000_0_0_0, 11'b1_0_0_0_0_0_0_000_0};
        tbl[12] = '{13'b0_1_1_0_0_0000_0_0_0, 11'b0_1_0_0_0_0_0_000_0};
        tbl[13] = '{13'b0_0_0_0_0_0000_0_0_0, 11'b0_0_1_0_0_0_0_001_0};
        tbl[14] = '{13'b0_0_0_0_1_0010_0_0_0, 11'b1_0_0_0_0_0_0_001_0};
        tbl[15] = '{13'b0_0_0_0_1_0010_1_0_0, 11'b1_0_0_0_0_1_0_001_0};
        tbl[16] = '{13'b0_0_0_0_1_0010_0_1_0, 11'b1_0_0_0_0_0_1_001_0};
        tbl[17] = '{13'b0_0_0_0_0_0000_0_0_0, 11'b1_0_0_0_0_0_0_000_0};
        tbl[18] = '{13'b0_0_0_0_1_1001_1_1_0, 11'b1_0_0_0_0_0_1_000_0};
        tbl[19] = '{13'b0_0_0_0_0_0000_0_0_0, 11'b1_0_0_0_0_0_0_000_1};

        // ---- table: single fadd, flush gating, reject, we=0, stall, stray ID
        do_reset();
        instr = FADD; rs1 = 32'h3F80_0000; rs2 = 32'h4000_0000;
        result_data = 32'h4040_0000; result_rd = 5'd5;
        for (int i = 0; i < 20; i++) begin
            @(negedge ck);
            {instr_valid, issue_ready, issue_accept, issue_writeback, result_valid,
             result_id, result_we, wb_ready, flush} = tbl[i].stim;
            #1;
            chk($sformatf("vec%0d", i),
                32'({instr_ready, issue_valid, commit_valid, commit_kill, illegal,
                     wb_valid, result_ready, outstanding, protocol_err}),
                32'(tbl[i].exp));
        end

        // ---- issue stall: payload held stable while issue_ready is low
        do_reset();
        @(negedge ck);
        instr_valid = 1'b1; instr = 32'h1234_5678; rs1 = 32'hAAAA_0001; rs2 = 32'h5555_0002;
        #1;
        chk("stall_intake", 32'(instr_ready), 32'h1);
        for (int k = 0; k < 3; k++) begin
            @(negedge ck);
            instr_valid = 1'b0; instr = 32'hDEAD_BEEF; rs1 = '0; rs2 = '1;
            #1;
            chk($sformatf("stall_ctl%0d", k), 32'({issue_valid, commit_valid, issue_id}),
                32'({1'b1, 1'b0, 4'd0}));
            chk($sformatf("stall_instr%0d", k), issue_instr, 32'h1234_5678);
            chk($sformatf("stall_ops%0d", k), issue_rs0 ^ issue_rs1, 32'hFFFF_0003);
        end
        @(negedge ck);
        issue_ready = 1'b1; issue_accept = 1'b1; issue_writeback = 1'b1;
        #1;
        chk("stall_release", 32'(issue_valid), 32'h1);
        @(negedge ck);
        issue_ready = 1'b0; issue_accept = 1'b0;
        #1;
        chk("stall_commit", 32'({commit_valid, commit_id, commit_kill, issue_valid}),
            32'({1'b1, 4'd0, 1'b0, 1'b0}));
        @(negedge ck); #1;
        chk("stall_commit_once", 32'(commit_valid), 32'h0);
        send_result(4'd0, 1'b1, 1'b1, 3'd0);

        // ---- fill to MAX_OUTSTANDING, reopen, then ID wrap and stray result
        do_reset();
        for (int i = 0; i < 4; i++) run_txn(1'b1, 1'b0, 4'(i));
        @(negedge ck);
        instr_valid = 1'b1;
        #1;
        chk("full_blocked", 32'({instr_ready, outstanding}), 32'({1'b0, 3'd4}));
        instr_valid = 1'b0;
        send_result(4'd0, 1'b1, 1'b1, 3'd3);
        chk("full_reopen", 32'(instr_ready), 32'h1);
        run_txn(1'b1, 1'b0, 4'd4);
        for (int i = 1; i <= 4; i++) send_result(4'(i), 1'b1, 1'b1, 3'(4 - i));
        for (int i = 5; i <= 16; i++) begin
            run_txn(1'b1, 1'b0, 4'(i));
            send_result(4'(i), 1'b1, 1'b1, 3'd0);
        end
        chk("wrap_perr_clear", 32'(protocol_err), 32'h0);
        send_result(4'd9, 1'b1, 1'b0, 3'd0);
        chk("stray_perr", 32'(protocol_err), 32'h1);

        // ---- flush: killed ID not tracked, DRAIN blocks intake until empty
        do_reset();
        run_txn(1'b1, 1'b0, 4'd0);
        run_txn(1'b1, 1'b1, 4'd1);
        chk("flush_out", 32'(outstanding), 32'h1);
        for (int k = 0; k < 2; k++) begin
            @(negedge ck); #1;
            chk($sformatf("drain_block%0d", k), 32'(instr_ready), 32'h0);
        end
        send_result(4'd1, 1'b1, 1'b0, 3'd1);
        chk("drain_killed_id", 32'(protocol_err), 32'h1);
        send_result(4'd0, 1'b1, 1'b1, 3'd0);
        chk("drain_last", 32'(instr_ready), 32'h0);
        @(negedge ck); #1;
        chk("drain_exit", 32'(instr_ready), 32'h1);

        // ---- watchdog: one accepted, no result
        do_reset();
        run_txn(1'b1, 1'b0, 4'd0);
        for (int k = 1; k <= 8; k++) begin
            logic exp_to;
`ifdef RVFPM_XIF_TIMEOUT_EN
            exp_to = (k >= 8);
`else
            exp_to = 1'b0;
`endif
            @(negedge ck); #1;
            chk($sformatf("timeout_c%0d", k), 32'(timeout_err), 32'(exp_to));
        end

        // ---- reset mid-transaction abandons it
        @(negedge ck);
        instr_valid = 1'b1;
        @(negedge ck);
        instr_valid = 1'b0;
        do_reset();
        @(negedge ck); #1;
        chk("post_reset", 32'({issue_valid, outstanding, instr_ready, timeout_err}),
            32'({1'b0, 3'd0, 1'b1, 1'b0}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
